// File: rtl/bt656_pkg.sv
// BT.656 decoder shared definitions.
// TRS codes, XYZ bit map, blanking words, phase roles.
package bt656_pkg;

  localparam logic [9:0] TRS_PRE0 = 10'h3FF;
  localparam logic [9:0] TRS_PRE1 = 10'h000;

  localparam logic [9:0] BLANK_C = 10'h200;
  localparam logic [9:0] BLANK_Y = 10'h040;

  localparam int XYZ_ONE = 9;
  localparam int XYZ_F   = 8;
  localparam int XYZ_V   = 7;
  localparam int XYZ_H   = 6;
  localparam int XYZ_P3  = 5;
  localparam int XYZ_P0  = 2;

  typedef enum logic [1:0] {
    PH_CB = 2'd0,
    PH_Y0 = 2'd1,
    PH_CR = 2'd2,
    PH_Y1 = 2'd3
  } phase_e;

  function automatic logic xyz_prot_ok(logic [9:0] xyz);
    logic       f;
    logic       v;
    logic       h;
    logic [3:0] p;
    f = xyz[XYZ_F];
    v = xyz[XYZ_V];
    h = xyz[XYZ_H];
    p = {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    return xyz[XYZ_P3:XYZ_P0] == p;
  endfunction

endpackage

// File: rtl/bt656_trs_detect.sv
// 4-word delay line with TRS tagging and XYZ check on the oldest word.
// Ports: clk, rst_n, cke_i, din_i -> w3_o, tag_o, xyz_valid_o, xyz_bad_o, f_o, v_o, h_o.
module bt656_trs_detect
  import bt656_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cke_i,
  input  logic [9:0] din_i,
  output logic [9:0] w3_o,
  output logic       tag_o,
  output logic       xyz_valid_o,
  output logic       xyz_bad_o,
  output logic       f_o,
  output logic       v_o,
  output logic       h_o
);

  logic [9:0] w0_q, w1_q, w2_q, w3_q;
  logic       tag1_q, tag2_q, tag3_q;
  logic       mk1_q, mk2_q, mk3_q;
  logic       trs_now;

  assign trs_now = (w3_q == TRS_PRE0) && (w2_q == TRS_PRE1) &&
                   (w1_q == TRS_PRE1) && w0_q[XYZ_ONE] &&
                   (w0_q[1:0] == 2'b00);

  // The preamble head is tagged directly at exit; the
  // three words behind it carry their tag down the line.
  assign w3_o        = w3_q;
  assign tag_o       = tag3_q | trs_now;
  assign xyz_valid_o = mk3_q & xyz_prot_ok(w3_q);
  assign xyz_bad_o   = mk3_q & ~xyz_prot_ok(w3_q);
  assign f_o         = w3_q[XYZ_F];
  assign v_o         = w3_q[XYZ_V];
  assign h_o         = w3_q[XYZ_H];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0_q   <= '0;
      w1_q   <= '0;
      w2_q   <= '0;
      w3_q   <= '0;
      tag1_q <= 1'b0;
      tag2_q <= 1'b0;
      tag3_q <= 1'b0;
      mk1_q  <= 1'b0;
      mk2_q  <= 1'b0;
      mk3_q  <= 1'b0;
    end else if (cke_i) begin
      w0_q   <= din_i;
      w1_q   <= w0_q;
      w2_q   <= w1_q;
      w3_q   <= w2_q;
      tag1_q <= trs_now;
      tag2_q <= tag1_q | trs_now;
      tag3_q <= tag2_q | trs_now;
      mk1_q  <= trs_now;
      mk2_q  <= mk1_q;
      mk3_q  <= mk2_q;
    end
  end

endmodule

// File: rtl/bt656_to_yuv422.sv
// BT.656 word stream to 4:2:2 Y/C pixel stream with regenerated timing.
// Ports: clk, rst_n, cke, din -> pix_cke, yuv_y/c/de/hs/vs, field, locked, xyz_err.
module bt656_to_yuv422
  import bt656_pkg::*;
#(
  parameter int MAX_LINE_WORDS = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cke,
  input  logic [9:0] din,
  output logic       pix_cke,
  output logic [9:0] yuv_y,
  output logic [9:0] yuv_c,
  output logic       yuv_de,
  output logic       yuv_hs,
  output logic       yuv_vs,
  output logic       field,
  output logic       locked,
  output logic       xyz_err
);

  localparam int CW = $clog2(MAX_LINE_WORDS + 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(MAX_LINE_WORDS);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_LINE_WORDS + 1);

  logic [9:0] w3;
  logic       tag;
  logic       xv, xb, xf, xvf, xh;

  bt656_trs_detect u_det (
    .clk         (clk),
    .rst_n       (rst_n),
    .cke_i       (cke),
    .din_i       (din),
    .w3_o        (w3),
    .tag_o       (tag),
    .xyz_valid_o (xv),
    .xyz_bad_o   (xb),
    .f_o         (xf),
    .v_o         (xvf),
    .h_o         (xh)
  );

  phase_e     ph_q, ph_d;
  logic [9:0] cr_q, cr_d;
  logic       ctag_q, ctag_d;
  logic       f_q, f_d, v_q, v_d, h_q, h_d;
  logic       sync_q, sync_d;
  logic       lk_q, lk_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic       pix_q, pix_d;
  logic [9:0] y_q, y_d, c_q, c_d;
  logic       de_q, de_d, hs_q, hs_d;
  logic       vs_q, vs_d, fld_q, fld_d;
  logic       err_q, err_d;

  // Counter saturates one past the limit so it never wraps
  // back into the locked range on a long TRS-less stream.
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    ph_d   = ph_q;
    cr_d   = cr_q;
    ctag_d = ctag_q;
    f_d    = f_q;
    v_d    = v_q;
    h_d    = h_q;
    sync_d = sync_q;
    lk_d   = lk_q;
    cnt_d  = cnt_q;
    pix_d  = 1'b0;
    y_d    = y_q;
    c_d    = c_q;
    de_d   = de_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    fld_d  = fld_q;
    err_d  = 1'b0;
    if (cke) begin
      cnt_d = cnt_inc;
      lk_d  = lk_q & (cnt_inc <= CNT_LIM);
      err_d = xb;
      unique case (ph_q)
        PH_CB, PH_CR: begin
          cr_d   = w3;
          ctag_d = tag;
        end
        PH_Y0, PH_Y1: begin
          // Nothing is strobed until the first valid TRS
          // after reset has given the decoder a phase.
          if (sync_q) begin
            pix_d = 1'b1;
            de_d  = ~h_q & ~v_q & lk_d & ~tag & ~ctag_q;
            hs_d  = h_q;
            vs_d  = v_q;
            fld_d = f_q;
            if (!tag) begin
              y_d = w3;
              c_d = cr_q;
            end
          end
        end
        default: ;
      endcase
      ph_d = phase_e'(ph_q + 2'd1);
      // A valid XYZ overrides both phase and lock tracking.
      if (xv) begin
        f_d    = xf;
        v_d    = xvf;
        h_d    = xh;
        cnt_d  = '0;
        lk_d   = 1'b1;
        sync_d = 1'b1;
        ph_d   = PH_CB;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q   <= PH_CB;
      cr_q   <= '0;
      ctag_q <= 1'b0;
      f_q    <= 1'b0;
      v_q    <= 1'b0;
      h_q    <= 1'b0;
      sync_q <= 1'b0;
      lk_q   <= 1'b0;
      cnt_q  <= '0;
      pix_q  <= 1'b0;
      y_q    <= '0;
      c_q    <= '0;
      de_q   <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      fld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      cr_q   <= cr_d;
      ctag_q <= ctag_d;
      f_q    <= f_d;
      v_q    <= v_d;
      h_q    <= h_d;
      sync_q <= sync_d;
      lk_q   <= lk_d;
      cnt_q  <= cnt_d;
      pix_q  <= pix_d;
      y_q    <= y_d;
      c_q    <= c_d;
      de_q   <= de_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      fld_q  <= fld_d;
      err_q  <= err_d;
    end
  end

  assign pix_cke = pix_q;
  assign yuv_y   = y_q;
  assign yuv_c   = c_q;
  assign yuv_de  = de_q;
  assign yuv_hs  = hs_q;
  assign yuv_vs  = vs_q;
  assign field   = fld_q;
  assign locked  = lk_q;
  assign xyz_err = err_q;

endmodule

// File: tb/tb_bt656_to_yuv422.sv
// Bench for bt656_to_yuv422: word-history model plus directed line scenarios.
// Drives clk/rst_n/cke/din, checks every output each cycle and logs strobes.
module tb_bt656_to_yuv422;
  import bt656_pkg::*;

  localparam int MAXW = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cke;
  logic [9:0] din;
  logic       pix_cke;
  logic [9:0] yuv_y, yuv_c;
  logic       yuv_de, yuv_hs, yuv_vs, field, locked, xyz_err;

  always #5 clk = ~clk;

  bt656_to_yuv422 #(.MAX_LINE_WORDS(MAXW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cke     (cke),
    .din     (din),
    .pix_cke (pix_cke),
    .yuv_y   (yuv_y),
    .yuv_c   (yuv_c),
    .yuv_de  (yuv_de),
    .yuv_hs  (yuv_hs),
    .yuv_vs  (yuv_vs),
    .field   (field),
    .locked  (locked),
    .xyz_err (xyz_err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_acc = 0;
  int err_w = 0;
  bit stall = 0;

  typedef struct {
    int         cyc;
    logic [9:0] y;
    logic [9:0] c;
    logic       de;
    logic       hs;
    logic       vs;
  } strobe_t;
  strobe_t slog[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // ---------------- model: whole accepted-word history ----------------
  logic [9:0] hist[$];
  int         m_ph, m_cnt;
  bit         m_lk, m_sync, m_f, m_v, m_h, m_ctag;
  logic [9:0] m_chroma;
  logic       e_pix, e_err, e_de, e_hs, e_vs, e_f;
  logic [9:0] e_y, e_c;

  function automatic bit trs_at(int k);
    logic [9:0] x;
    if (k < 0 || k + 3 >= hist.size()) return 0;
    x = hist[k+3];
    return hist[k] == 10'h3FF && hist[k+1] == 10'h000 &&
           hist[k+2] == 10'h000 && x[9] && x[1:0] == 2'b00;
  endfunction

  function automatic bit prot_ok(logic [9:0] x);
    bit f, v, h;
    f = x[8]; v = x[7]; h = x[6];
    return x[5] == (v ^ h) && x[4] == (f ^ h) &&
           x[3] == (f ^ v) && x[2] == (f ^ v ^ h);
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (4) hist.push_back(10'h000);
    m_ph = 0; m_cnt = 0; m_lk = 0; m_sync = 0;
    m_f = 0; m_v = 0; m_h = 0; m_ctag = 0; m_chroma = '0;
    e_pix = 0; e_err = 0; e_de = 0; e_hs = 0; e_vs = 0; e_f = 0;
    e_y = '0; e_c = '0;
  endtask

  // Each accepted word pushes the word accepted four words
  // earlier out of the decoder.
  task automatic model_step(input logic [9:0] w_in);
    int         j;
    logic [9:0] w;
    bit         tag, isx, good;
    hist.push_back(w_in);
    j = hist.size() - 5;
    w = hist[j];
    tag = trs_at(j) || trs_at(j-1) || trs_at(j-2) || trs_at(j-3);
    isx = trs_at(j-3);
    good = isx && prot_ok(w);
    e_err = isx && !good;
    e_pix = 0;
    m_cnt++;
    if (m_cnt > MAXW) m_lk = 0;
    if (m_ph % 2 == 0) begin
      m_chroma = w;
      m_ctag = tag;
    end else if (m_sync) begin
      e_pix = 1;
      e_de = !m_h && !m_v && m_lk && !tag && !m_ctag;
      e_hs = m_h; e_vs = m_v; e_f = m_f;
      if (!tag) begin
        e_y = w;
        e_c = m_chroma;
      end
    end
    m_ph = (m_ph + 1) % 4;
    if (good) begin
      m_f = w[8]; m_v = w[7]; m_h = w[6];
      m_cnt = 0; m_lk = 1; m_sync = 1; m_ph = 0;
    end
  endtask

  // ---------------- per-cycle compare and strobe log ----------------
  always @(posedge clk) begin
    strobe_t s;
    cyc++;
    if (!rst_n) model_reset();
    else if (cke) model_step(din);
    else begin
      e_pix = 0;
      e_err = 0;
    end
    #1;
    if (e_pix)
      check("strobe",
            {pix_cke, xyz_err, locked, yuv_y, yuv_c, yuv_de,
             yuv_hs, yuv_vs, field},
            {e_pix, e_err, m_lk, e_y, e_c, e_de, e_hs, e_vs, e_f});
    else
      check("idle", {pix_cke, xyz_err, locked}, {e_pix, e_err, m_lk});
    if (pix_cke) begin
      s.cyc = cyc; s.y = yuv_y; s.c = yuv_c;
      s.de = yuv_de; s.hs = yuv_hs; s.vs = yuv_vs;
      slog.push_back(s);
    end
    if (xyz_err) err_w++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [9:0] w);
    if (stall) begin
      @(negedge clk);
      cke = 1'b0;
      din = 10'($urandom_range(0, 1023));
    end
    @(negedge clk);
    cke = 1'b1;
    din = w;
    last_acc = cyc + 1;
  endtask

  task automatic send4(input logic [9:0] a, input logic [9:0] b,
                       input logic [9:0] c, input logic [9:0] d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic pad(input int n);
    for (int i = 0; i < n; i++) send((i % 2) ? BLANK_Y : BLANK_C);
  endtask

  task automatic idle();
    @(negedge clk);
    cke = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_log();
    @(posedge clk);
    #2;
    slog.delete();
    err_w = 0;
  endtask

  function automatic int count_de();
    int n = 0;
    foreach (slog[i]) if (slog[i].de) n++;
    return n;
  endfunction

  function automatic int count_bad_de();
    int n = 0;
    foreach (slog[i])
      if (slog[i].de && (slog[i].y == 10'h3FF || slog[i].y == 10'h000 ||
                         slog[i].c == 10'h3FF || slog[i].c == 10'h000))
        n++;
    return n;
  endfunction

  task automatic chk_px(input string name, input int k, input logic [9:0] y,
                        input logic [9:0] c, input logic de,
                        input logic hs, input logic vs);
    if (k < slog.size())
      check(name, {slog[k].y, slog[k].c, slog[k].de, slog[k].hs, slog[k].vs},
            {y, c, de, hs, vs});
    else
      check(name, slog.size(), k + 1);
  endtask

  // EAV, blanking, SAV(sav), four data words, EAV, blanking.
  // The log holds only strobes of the data words onward.
  task automatic run_line(input logic [9:0] sav, input bit s, output int t150);
    stall = s;
    send4(10'h3FF, 10'h000, 10'h000, 10'h274);
    send4(BLANK_C, BLANK_Y, BLANK_C, BLANK_Y);
    send4(10'h3FF, 10'h000, 10'h000, sav);
    send(10'h100);
    send(10'h150);
    t150 = last_acc;
    send(10'h180);
    send(10'h160);
    clear_log();
    send4(10'h3FF, 10'h000, 10'h000, 10'h274);
    pad(8);
    stall = 0;
    idle();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int t;
    rst_n = 1'b0;
    cke   = 1'b0;
    din   = '0;
    repeat (3) @(negedge clk);
    check("reset_state",
          {pix_cke, yuv_y, yuv_c, yuv_de, yuv_hs, yuv_vs, field, locked,
           xyz_err}, 0);
    rst_n = 1'b1;

    // active line: latency = 4 edges after the Y word is sampled,
    // so a downstream register sees pix_cke at the fifth edge
    run_line(10'h200, 0, t);
    chk_px("act_px0", 0, 10'h150, 10'h100, 1, 0, 0);
    chk_px("act_px1", 1, 10'h160, 10'h180, 1, 0, 0);
    check("act_n_de", count_de(), 2);
    check("act_lat", slog.size() > 0 ? slog[0].cyc - t : -1, 4);
    check("act_locked", locked, 1);

    // vertical blanking: SAV with V=1
    run_line(10'h2AC, 0, t);
    chk_px("vbl_px0", 0, 10'h150, 10'h100, 0, 0, 1);
    chk_px("vbl_px1", 1, 10'h160, 10'h180, 0, 0, 1);
    check("vbl_n_de", count_de(), 0);

    // corrupt XYZ mid-line
    send4(10'h3FF, 10'h000, 10'h000, 10'h274);
    send4(BLANK_C, BLANK_Y, BLANK_C, BLANK_Y);
    send4(10'h3FF, 10'h000, 10'h000, 10'h200);
    send4(10'h100, 10'h150, 10'h180, 10'h160);
    clear_log();
    send4(10'h3FF, 10'h000, 10'h000, 10'h27C);
    send4(10'h110, 10'h120, 10'h130, 10'h140);
    send4(10'h3FF, 10'h000, 10'h000, 10'h274);
    pad(8);
    idle();
    check("bad_err_pulses", err_w, 1);
    chk_px("bad_px0", 0, 10'h150, 10'h100, 1, 0, 0);
    chk_px("bad_px1", 1, 10'h160, 10'h180, 1, 0, 0);
    chk_px("bad_hold0", 2, 10'h160, 10'h180, 0, 0, 0);
    chk_px("bad_hold1", 3, 10'h160, 10'h180, 0, 0, 0);
    chk_px("bad_px2", 4, 10'h120, 10'h110, 1, 0, 0);
    chk_px("bad_px3", 5, 10'h140, 10'h130, 1, 0, 0);
    check("bad_preamble_de", count_bad_de(), 0);

    // lock loss: 70 words after SAV, limit 64
    send4(10'h3FF, 10'h000, 10'h000, 10'h274);
    send4(BLANK_C, BLANK_Y, BLANK_C, BLANK_Y);
    send4(10'h3FF, 10'h000, 10'h000, 10'h200);
    slog.delete();
    for (int k = 1; k <= 70; k++) send(10'(10'h100 + k));
    @(posedge clk);
    #2;
    check("lk_dropped", locked, 0);
    check("lk_n_de", count_de(), 32);
    check("lk_last_de", slog.size() > 0 ? slog[$].de : 1'b1, 0);
    slog.delete();
    send4(10'h3FF, 10'h000, 10'h000, 10'h200);
    send4(10'h100, 10'h150, 10'h180, 10'h160);
    send4(10'h3FF, 10'h000, 10'h000, 10'h274);
    pad(8);
    idle();
    check("lk_restored", locked, 1);
    check("lk_re_n_de", count_de(), 2);

    // cke toggling every cycle: same data, doubled latency
    run_line(10'h200, 1, t);
    chk_px("stl_px0", 0, 10'h150, 10'h100, 1, 0, 0);
    chk_px("stl_px1", 1, 10'h160, 10'h180, 1, 0, 0);
    check("stl_n_de", count_de(), 2);
    check("stl_lat", slog.size() > 0 ? slog[0].cyc - t : -1, 8);

    // asynchronous reset mid-line
    send4(10'h3FF, 10'h000, 10'h000, 10'h274);
    send4(BLANK_C, BLANK_Y, BLANK_C, BLANK_Y);
    send4(10'h3FF, 10'h000, 10'h000, 10'h200);
    send4(10'h100, 10'h150, 10'h180, 10'h160);
    send(10'h110);
    @(posedge clk);
    #2;
    check("pre_rst_locked", locked, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async",
          {pix_cke, yuv_y, yuv_c, yuv_de, yuv_hs, yuv_vs, field, locked,
           xyz_err}, 0);
    @(negedge clk);
    cke = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    slog.delete();
    for (int k = 0; k < 8; k++) send(10'(10'h120 + k));
    pad(4);
    @(posedge clk);
    #2;
    check("rst_no_strobe", slog.size(), 0);
    check("rst_unlocked", locked, 0);
    idle();
    run_line(10'h200, 0, t);
    chk_px("rst_px0", 0, 10'h150, 10'h100, 1, 0, 0);
    check("rst_n_de", count_de(), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bt656_to_yuv422.md
# bt656_to_yuv422

Front-end decoder upstream of `yuv422_to_rgb`. Accepts a 10-bit BT.656 multiplexed word stream (Cb Y Cr Y … with embedded EAV/SAV timing reference codes) and de-multiplexes it into the separate `yuv_y`/`yuv_c` 4:2:2 pixel stream. It regenerates `yuv_hs`/`yuv_vs`/`yuv_de` from the embedded F/V/H flags and supplies a per-pixel clock enable that drives the converter's `cke`.

## Interface
- `MAX_LINE_WORDS`, 4096: words allowed between two valid TRS before lock is dropped; counter width is `$clog2(MAX_LINE_WORDS+1)`.
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cke`  in  1  input word qualifier; `din` accepted only on cycles with `cke`=1.
- `din`  in  10  BT.656 word.
- `pix_cke`  out  1  one-cycle strobe; `yuv_*` outputs are valid and update only on it.
- `yuv_y`  out  10  luma.
- `yuv_c`  out  10  chroma: Cb on even pixels, Cr on odd pixels.
- `yuv_de`  out  1  active video.
- `yuv_hs`  out  1  H flag (1 from EAV to SAV).
- `yuv_vs`  out  1  V flag.
- `field`  out  1  F flag.
- `locked`  out  1  a valid TRS was seen within the last `MAX_LINE_WORDS` words.
- `xyz_err`  out  1  one-cycle pulse when a preamble is followed by an XYZ failing protection.

## Operation
- Accepted words shift through a 4-stage delay line w0 (newest) to w3. All decoding acts on w3.
- TRS detection: a TRS is present when (w3,w2,w1)=(0x3FF,0x000,0x000) and w0[9]=1 and w0[1:0]=0. All four TRS words are tagged as timing and are never emitted as pixel data.
- XYZ layout: [8]=F, [7]=V, [6]=H, [5:2]=P3..P0. Protection bits: P3=V^H, P2=F^H, P1=F^V, P0=F^V^H.
- Valid XYZ:
  - On exit from w3, latch F/V/H.
  - Reset the phase counter so the next word is phase 0 (Cb).
  - Clear the line-word counter and set `locked`.
- Invalid XYZ: pulse `xyz_err` when w3 exits. Flags, phase and lock counter are unchanged. The preamble words are still suppressed.
- Phase cycles 0→3 with roles Cb, Y0, Cr, Y1 and wraps.
  - On a Cb or Cr word exiting w3: hold it in a chroma register.
  - On a Y0 word exiting: emit pixel (Y0, Cb).
  - On a Y1 word exiting: emit pixel (Y1, Cr).
- Emit means, on the next clk: `pix_cke`=1, `yuv_y`/`yuv_c` loaded.
  - `yuv_de` = !H & !V & locked & (neither word of the pair is TRS-tagged).
  - `yuv_hs`=H, `yuv_vs`=V, `field`=F.
- Blanking words (0x200/0x040) are emitted with `yuv_de`=0 to keep the pixel cadence.
- Pixel slots whose Y word is TRS-tagged are still strobed, with `yuv_de`=0 and data held.
- Line-word counter increments per accepted word. When it exceeds `MAX_LINE_WORDS`, `locked` drops and `yuv_de` is forced 0 until the next valid XYZ.
- A mid-line valid XYZ always realigns phase immediately. A partial pixel pair is discarded.

## Timing
- Reset values: all outputs 0, delay line 0x000, phase 0, counters 0.
- Latency (`cke`=1 continuously): a Y word sampled at edge n produces `pix_cke` high in cycle n+5. Each `cke`=0 cycle adds one cycle.
- `pix_cke` is high at most every second accepted word. It never asserts on a cycle whose sampling edge had `cke`=0.
- `cke`=0 freezes the delay line, phase and counters. Outputs hold and `pix_cke`=0.
- Reset mid-line: asynchronous clear; decoding restarts unlocked and needs a fresh valid TRS.
- When a TRS exit and counter overflow coincide, the valid TRS wins (`locked` stays 1).

## Structure
- Shared package `bt656_pkg`:
  - TRS_PRE0=0x3FF, TRS_PRE1=0x000.
  - XYZ bit indices.
  - Function `xyz_prot_ok(logic [9:0])`.
  - Blanking constants 0x200/0x040.
- One sub-module `bt656_trs_detect`: the delay line, TRS tagging and XYZ check. It outputs w3, its tag, and strobes `xyz_valid`/`xyz_bad` plus F/V/H. The top level holds the phase counter, lock counter and output registers.

## Test plan
- Reset: assert `rst_n`=0 mid-stream → all outputs 0 within the same cycle; no `pix_cke` until a valid TRS then data.
- Active line: EAV (…0x274), 4 blanking words, SAV (0x3FF,0x000,0x000,0x200), then 0x100,0x150,0x180,0x160 → two strobes: (y=0x150,c=0x100,de=1), (y=0x160,c=0x180,de=1), hs=0, vs=0, first strobe at cycle n+5 of the 0x150 word.
- Vertical blanking: SAV XYZ 0x2AC (V=1) followed by the same 4 data words → strobes with de=0, vs=1, hs=0.
- Corrupt XYZ: preamble then 0x27C → `xyz_err` one-cycle pulse; F/V/H and phase unchanged; no pixel carries 0x3FF/0x000 preamble data with de=1.
- Lock loss: `MAX_LINE_WORDS`=64, a valid SAV then 65 data words with no TRS → `locked` falls, de=0 afterwards; next valid SAV restores it.
- `cke` stall: repeat the active-line test with `cke` toggling every cycle → identical strobe data sequence, with latency doubled.
